// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between the
// dcache (port 0) and the icache (port 1); one access is in flight at a time.
module mem_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int MEM_LATENCY    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [3:0]                mem_rw_flag_i,
  input  logic [2*ADDR_WIDTH-1:0]   mem_addr_i,
  input  logic [2*DATA_WIDTH-1:0]   mem_w_data_i,
  input  logic [7:0]                mem_w_mask_i,
  output logic [2*DATA_WIDTH-1:0]   mem_r_data_o,
  output logic [1:0]                mem_busy_o,
  output logic [1:0]                mem_done_o,
  output logic                      ram_ce_o,
  output logic                      ram_we_o,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0]     ram_w_data_o,
  output logic [3:0]                ram_w_mask_o,
  input  logic [DATA_WIDTH-1:0]     ram_r_data_i
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] LAT_LOAD = 4'(MEM_LATENCY - 1);

  state_t                    state_r;
  state_t                    state_s;
  logic [1:0]                pending_s;
  logic [1:0]                mask_r;
  logic                      grant_s;
  logic                      grant_fire_s;
  logic                      grant_r;
  logic                      last_grant_r;
  logic                      is_write_r;
  logic [3:0]                lat_cnt_r;
  logic                      read_capture_s;
  logic [ADDR_WIDTH-1:0]     sel_addr_s;
  logic [DATA_WIDTH-1:0]     sel_data_s;
  logic [3:0]                sel_mask_s;
  logic                      sel_write_s;
  logic                      unused_addr_s;

  logic [2*DATA_WIDTH-1:0]   r_data_r;
  logic [1:0]                busy_r;
  logic [1:0]                done_r;
  logic                      ram_ce_r;
  logic                      ram_we_r;
  logic [RAM_ADDR_WIDTH-1:0] ram_addr_r;
  logic [DATA_WIDTH-1:0]     ram_w_data_r;
  logic [3:0]                ram_w_mask_r;

  function automatic logic [1:0] port_onehot(input logic port);
    port_onehot = port ? 2'b10 : 2'b01;
  endfunction

  // Pending ports, round-robin choice and the chosen port's request fields
  always_comb begin
    pending_s[0] = (mem_rw_flag_i[1:0] != 2'b00) && !mask_r[0];
    pending_s[1] = (mem_rw_flag_i[3:2] != 2'b00) && !mask_r[1];
    grant_s      = 1'b0;
    case (pending_s)
      2'b01:   grant_s = 1'b0;
      2'b10:   grant_s = 1'b1;
      2'b11:   grant_s = ~last_grant_r;
      default: grant_s = 1'b0;
    endcase
    grant_fire_s = (state_r == ST_IDLE) && (pending_s != 2'b00);
    if (grant_s) begin
      sel_addr_s  = mem_addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH];
      sel_data_s  = mem_w_data_i[2*DATA_WIDTH-1:DATA_WIDTH];
      sel_mask_s  = mem_w_mask_i[7:4];
      sel_write_s = mem_rw_flag_i[3];
    end else begin
      sel_addr_s  = mem_addr_i[ADDR_WIDTH-1:0];
      sel_data_s  = mem_w_data_i[DATA_WIDTH-1:0];
      sel_mask_s  = mem_w_mask_i[3:0];
      sel_write_s = mem_rw_flag_i[1];
    end
  end

  // Byte-offset and high address bits play no part in the word address
  assign unused_addr_s = ^{sel_addr_s[ADDR_WIDTH-1:RAM_ADDR_WIDTH+2], sel_addr_s[1:0]};

  // Next-state logic of the access sequencer
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_fire_s) state_s = ST_ISSUE;
        else              state_s = ST_IDLE;
      end
      ST_ISSUE: begin
        if (is_write_r) state_s = ST_DONE;
        else            state_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (lat_cnt_r == 4'd0) state_s = ST_DONE;
        else                   state_s = ST_WAIT;
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  assign read_capture_s = (state_r == ST_WAIT) && (lat_cnt_r == 4'd0);

  // Sequencer state, grant history, duplicate-service mask and latency counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      grant_r      <= 1'b0;
      last_grant_r <= 1'b1;
      mask_r       <= 2'b00;
      is_write_r   <= 1'b0;
      lat_cnt_r    <= 4'd0;
    end else begin
      state_r <= state_s;
      // The finished port is masked for one IDLE cycle while its cache drops the flag
      mask_r  <= (state_r == ST_DONE) ? port_onehot(grant_r) : 2'b00;
      if (grant_fire_s) begin
        grant_r    <= grant_s;
        is_write_r <= sel_write_s;
      end
      if (state_r == ST_DONE) begin
        last_grant_r <= grant_r;
      end
      if (state_r == ST_ISSUE) begin
        lat_cnt_r <= LAT_LOAD;
      end else if ((state_r == ST_WAIT) && (lat_cnt_r != 4'd0)) begin
        lat_cnt_r <= lat_cnt_r - 4'd1;
      end
    end
  end

  // Registered cache-side and RAM-side outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_r     <= '0;
      busy_r       <= 2'b00;
      done_r       <= 2'b00;
      ram_ce_r     <= 1'b0;
      ram_we_r     <= 1'b0;
      ram_addr_r   <= '0;
      ram_w_data_r <= '0;
      ram_w_mask_r <= 4'b0000;
    end else begin
      busy_r   <= (state_s != ST_IDLE) ? 2'b11 : 2'b00;
      done_r   <= (state_s == ST_DONE) ? port_onehot(grant_r) : 2'b00;
      ram_ce_r <= grant_fire_s;
      ram_we_r <= grant_fire_s && sel_write_s;
      if (grant_fire_s) begin
        ram_addr_r   <= sel_addr_s[RAM_ADDR_WIDTH+1:2];
        ram_w_data_r <= sel_data_s;
        ram_w_mask_r <= sel_mask_s;
      end
      // Only the granted port's read slice is ever written
      if (read_capture_s) begin
        if (grant_r) r_data_r[2*DATA_WIDTH-1:DATA_WIDTH] <= ram_r_data_i;
        else         r_data_r[DATA_WIDTH-1:0]            <= ram_r_data_i;
      end
    end
  end

  assign mem_r_data_o = r_data_r;
  assign mem_busy_o   = busy_r;
  assign mem_done_o   = done_r;
  assign ram_ce_o     = ram_ce_r;
  assign ram_we_o     = ram_we_r;
  assign ram_addr_o   = ram_addr_r;
  assign ram_w_data_o = ram_w_data_r;
  assign ram_w_mask_o = ram_w_mask_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: behavioural RAM, per-port expectation
// queues filled at request time, and a monitor that checks strobes and dones.
module tb_mem_arbiter;
  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int RAW    = 17;
  localparam int LAT    = 2;
  localparam int BUDGET = 64;

  typedef struct packed {
    logic        wr;
    logic [16:0] word;
    logic [31:0] data;
    logic [3:0]  mask;
    logic [31:0] exp_rd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  flag_p  [2];
  logic [31:0] addr_p  [2];
  logic [31:0] wdata_p [2];
  logic [3:0]  mask_p  [2];

  logic [3:0]     mem_rw_flag;
  logic [63:0]    mem_addr;
  logic [63:0]    mem_w_data;
  logic [7:0]     mem_w_mask;
  logic [63:0]    mem_r_data;
  logic [1:0]     mem_busy;
  logic [1:0]     mem_done;
  logic           ram_ce;
  logic           ram_we;
  logic [RAW-1:0] ram_addr;
  logic [31:0]    ram_wdata;
  logic [3:0]     ram_wmask;
  logic [31:0]    ram_rdata;

  assign mem_rw_flag = {flag_p[1], flag_p[0]};
  assign mem_addr    = {addr_p[1], addr_p[0]};
  assign mem_w_data  = {wdata_p[1], wdata_p[0]};
  assign mem_w_mask  = {mask_p[1], mask_p[0]};

  mem_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RAM_ADDR_WIDTH(RAW), .MEM_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .mem_rw_flag_i(mem_rw_flag), .mem_addr_i(mem_addr),
    .mem_w_data_i(mem_w_data), .mem_w_mask_i(mem_w_mask),
    .mem_r_data_o(mem_r_data), .mem_busy_o(mem_busy), .mem_done_o(mem_done),
    .ram_ce_o(ram_ce), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
    .ram_w_data_o(ram_wdata), .ram_w_mask_o(ram_wmask), .ram_r_data_i(ram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural RAM and reference memory
  logic [31:0] ram_mem [256];
  logic [31:0] ref_mem [256];
  logic [31:0] rd_pipe [LAT];
  int          cyc = 0;

  assign ram_rdata = rd_pipe[LAT-1];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mk_addr(input int p);
    logic [31:0] r;
    logic [6:0]  w;
    r = $urandom();
    w = 7'($urandom_range(0, 127));
    r[18:10] = 9'd0;
    r[9:2]   = {p[0], w};
    return r;
  endfunction

  // RAM: writes land at the strobe edge, read data appears LAT cycles after the strobe
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_ce && ram_we) ram_mem[ram_addr[7:0]] <= merge(ram_mem[ram_addr[7:0]], ram_wdata, ram_wmask);
    rd_pipe[0] <= (ram_ce && !ram_we) ? ram_mem[ram_addr[7:0]] : (32'hA5A5_0000 | {16'h0000, cyc[15:0]});
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  // Scoreboard state
  exp_t        q0[$];
  exp_t        q1[$];
  int          done_cnt [2];
  int          outst [2];
  int          last_ce_cyc [2];
  int          ce_total = 0;
  int          grant_log[$];
  int          ce_cyc_log[$];
  logic [31:0] hold_exp [2];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: compare every strobe and every done against the expectation queues
  always begin
    @(posedge clk);
    #1;
    if (!rst) begin
      if (ram_ce) begin
        int   p;
        int   qs;
        exp_t e;
        if (q0.size() != 0 && q1.size() == 0)      p = 0;
        else if (q1.size() != 0 && q0.size() == 0) p = 1;
        else                                       p = ram_addr[7] ? 1 : 0;
        qs = (p == 0) ? q0.size() : q1.size();
        check("strobe_has_request", 64'(qs != 0), 64'd1);
        if (qs != 0) begin
          e = (p == 0) ? q0[0] : q1[0];
          check("strobe_addr", 64'(ram_addr), 64'(e.word));
          check("strobe_we", 64'(ram_we), 64'(e.wr));
          if (e.wr) begin
            check("strobe_wdata", 64'(ram_wdata), 64'(e.data));
            check("strobe_wmask", 64'(ram_wmask), 64'(e.mask));
          end
          check("one_strobe_per_req", 64'(outst[p]), 64'd0);
          outst[p]++;
        end
        ce_total++;
        last_ce_cyc[p] = cyc;
        grant_log.push_back(p);
        ce_cyc_log.push_back(cyc);
      end
      for (int pi = 0; pi < 2; pi++) begin
        if (mem_done[pi]) begin
          exp_t e;
          int   qs;
          qs = (pi == 0) ? q0.size() : q1.size();
          check("done_has_request", 64'(qs != 0), 64'd1);
          check("done_busy", 64'(mem_busy), 64'd3);
          if (qs != 0) begin
            if (pi == 0) e = q0.pop_front();
            else         e = q1.pop_front();
            check("done_after_one_strobe", 64'(outst[pi]), 64'd1);
            outst[pi] = 0;
            if (!e.wr) hold_exp[pi] = e.exp_rd;
          end
          check("rdata_p0", 64'(mem_r_data[31:0]), 64'(hold_exp[0]));
          check("rdata_p1", 64'(mem_r_data[63:32]), 64'(hold_exp[1]));
          done_cnt[pi]++;
        end
      end
    end
  end

  // One cache request: push the expectation, hold until done, then release
  task automatic do_req(input int p, input logic [1:0] rw, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] mask, input int hold_extra,
                        output int t_req, output int t_done);
    exp_t        e;
    int          base;
    int          n;
    logic [16:0] word;
    @(negedge clk);
    word     = addr[18:2];
    e.wr     = rw[1];
    e.word   = word;
    e.data   = data;
    e.mask   = mask;
    e.exp_rd = ref_mem[word[7:0]];
    if (rw[1]) ref_mem[word[7:0]] = merge(ref_mem[word[7:0]], data, mask);
    if (p == 0) q0.push_back(e);
    else        q1.push_back(e);
    flag_p[p] = rw; addr_p[p] = addr; wdata_p[p] = data; mask_p[p] = mask;
    t_req = cyc;
    base  = done_cnt[p];
    n     = 0;
    while (done_cnt[p] == base && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check("done_within_budget", 64'(done_cnt[p] != base), 64'd1);
    t_done = cyc;
    repeat (hold_extra) @(negedge clk);
    flag_p[p] = 2'b00; addr_p[p] = $urandom(); wdata_p[p] = $urandom(); mask_p[p] = 4'($urandom());
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          t0, td, ta0, tda0, base_ce, base_done;
    logic [31:0] v, old8, a;
    logic [63:0] all_out;
    for (int p = 0; p < 2; p++) begin
      flag_p[p] = 2'b00; addr_p[p] = 32'h0; wdata_p[p] = 32'h0; mask_p[p] = 4'h0;
      done_cnt[p] = 0; outst[p] = 0; last_ce_cyc[p] = 0; hold_exp[p] = 32'h0;
    end
    for (int i = 0; i < 256; i++) begin
      v = $urandom() | 32'h1;
      ram_mem[i] <= v;
      ref_mem[i] = v;
    end
    ram_mem[4] <= 32'hDEAD_BEEF;
    ref_mem[4] = 32'hDEAD_BEEF;
    for (int i = 0; i < LAT; i++) rd_pipe[i] <= 32'h0;

    repeat (3) @(negedge clk);
    check("reset_busy", 64'(mem_busy), 64'd0);
    check("reset_done", 64'(mem_done), 64'd0);
    check("reset_ce_we", 64'({ram_ce, ram_we}), 64'd0);
    check("reset_ram_addr", 64'(ram_addr), 64'd0);
    check("reset_ram_wdata_mask", 64'({ram_wdata, ram_wmask}), 64'd0);
    check("reset_rdata", mem_r_data, 64'd0);
    rst = 1'b0;

    // Both ports read from reset: port 0 first, then strict alternation
    grant_log.delete();
    ce_cyc_log.delete();
    fork
      begin : port0_reads
        int tx, ty;
        for (int k = 0; k < 3; k++) begin
          do_req(0, 2'b01, mk_addr(0), $urandom(), 4'hF, 0, tx, ty);
          if (k == 0) begin ta0 = tx; tda0 = ty; end
        end
      end
      begin : port1_reads
        int tx, ty;
        for (int k = 0; k < 3; k++) do_req(1, 2'b01, mk_addr(1), $urandom(), 4'hF, 0, tx, ty);
      end
    join
    check("alt_grant_count", 64'(grant_log.size()), 64'd6);
    for (int k = 0; k < 6; k++) if (k < grant_log.size()) check("alt_grant_order", 64'(grant_log[k]), 64'(k % 2));
    if (ce_cyc_log.size() >= 2) begin
      check("alt_first_strobe_cycle", 64'(ce_cyc_log[0]), 64'(ta0 + 1));
      check("alt_first_done_cycle", 64'(tda0), 64'(ta0 + 2 + LAT));
      check("alt_p1_in_masked_idle", 64'(ce_cyc_log[1]), 64'(tda0 + 2));
    end

    // Port 0 read of word 4
    do_req(0, 2'b01, 32'h0000_0010, 32'h0, 4'h0, 0, t0, td);
    check("p0_read_strobe_cycle", 64'(last_ce_cyc[0]), 64'(t0 + 1));
    check("p0_read_done_cycle", 64'(td), 64'(t0 + 4));
    check("p0_read_data", 64'(mem_r_data[31:0]), 64'h0000_0000_DEAD_BEEF);
    repeat (3) @(negedge clk);
    check("p0_read_data_held", 64'(mem_r_data[31:0]), 64'h0000_0000_DEAD_BEEF);

    // Port 1 partial write to word 8
    old8 = ref_mem[8];
    do_req(1, 2'b10, 32'h0000_0020, 32'h1122_3344, 4'b0011, 0, t0, td);
    check("p1_write_strobe_cycle", 64'(last_ce_cyc[1]), 64'(t0 + 1));
    check("p1_write_done_cycle", 64'(td), 64'(t0 + 2));
    check("p1_write_bytes", 64'(ram_mem[8]), 64'({old8[31:16], 16'h3344}));

    // Flag held one cycle past done: no duplicate service
    base_ce   = ce_total;
    base_done = done_cnt[0];
    do_req(0, 2'b01, mk_addr(0), 32'h0, 4'h0, 1, t0, td);
    repeat (4) @(negedge clk);
    check("held_flag_one_strobe", 64'(ce_total - base_ce), 64'd1);
    check("held_flag_one_done", 64'(done_cnt[0] - base_done), 64'd1);

    // Code 11 behaves as a write
    do_req(0, 2'b11, 32'h0000_0078, 32'hCAFE_F00D, 4'b1111, 0, t0, td);
    check("rw11_done_cycle", 64'(td), 64'(t0 + 2));
    check("rw11_ram_word", 64'(ram_mem[30]), 64'hCAFE_F00D);

    // Reset during WAIT of a port 1 read
    @(negedge clk);
    a = mk_addr(1);
    begin
      exp_t e;
      e.wr = 1'b0; e.word = a[18:2]; e.data = 32'h0; e.mask = 4'h0; e.exp_rd = ref_mem[a[9:2]];
      q1.push_back(e);
    end
    flag_p[1] = 2'b01; addr_p[1] = a;
    t0        = cyc;
    base_done = done_cnt[1];
    @(negedge clk);
    @(negedge clk);
    check("rst_wait_busy", 64'(mem_busy), 64'd3);
    rst = 1'b1;
    flag_p[1] = 2'b00;
    @(negedge clk);
    all_out = {26'h0, mem_busy, mem_done, ram_ce, ram_we, ram_wmask, ram_addr, 8'h0};
    check("rst_outputs_zero", all_out, 64'd0);
    check("rst_rdata_zero", mem_r_data, 64'd0);
    rst = 1'b0;
    q0.delete(); q1.delete();
    outst[0] = 0; outst[1] = 0; hold_exp[0] = 32'h0; hold_exp[1] = 32'h0;
    repeat (6) @(negedge clk);
    check("rst_no_done", 64'(done_cnt[1]), 64'(base_done));
    check("rst_p1_rdata", 64'(mem_r_data[63:32]), 64'd0);
    do_req(1, 2'b01, mk_addr(1), 32'h0, 4'h0, 0, t0, td);
    check("after_rst_read_done_cycle", 64'(td), 64'(t0 + 2 + LAT));

    // Randomized concurrent traffic on disjoint halves of the RAM
    fork
      begin : rand_p0
        int tx, ty;
        for (int k = 0; k < 25; k++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          do_req(0, 2'($urandom_range(1, 3)), mk_addr(0), $urandom(), 4'($urandom()),
                 int'($urandom_range(0, 1)), tx, ty);
        end
      end
      begin : rand_p1
        int tx, ty;
        for (int k = 0; k < 25; k++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          do_req(1, 2'($urandom_range(1, 3)), mk_addr(1), $urandom(), 4'($urandom()),
                 int'($urandom_range(0, 1)), tx, ty);
        end
      end
    join
    repeat (4) @(negedge clk);
    check("queues_drained", 64'(q0.size() + q1.size()), 64'd0);
    for (int i = 0; i < 256; i++) begin
      if (ram_mem[i] !== ref_mem[i]) check("ram_contents", 64'(ram_mem[i]), 64'(ref_mem[i]));
    end
    check("final_busy_idle", 64'(mem_busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
